// File: rtl/weight_streamer.sv
// weight_streamer: streams a window of BRAM words onto a valid/ready weight bus through a
// 2-entry FIFO. Define WEIGHT_STREAMER_CHECKSUM_EN to add a running checksum output.
module weight_streamer #(
    parameter int DATA_WIDTH      = 32,
    parameter int MEM_DEPTH       = 1024,
    parameter int BRAM_ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [BRAM_ADDR_WIDTH-1:0] base_addr,
    input  logic [BRAM_ADDR_WIDTH:0]   num_words,
    output logic                       busy,
    output logic                       done,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_addr,
    output logic                       bram_en,
    input  logic [DATA_WIDTH-1:0]      bram_dout,
    output logic [DATA_WIDTH-1:0]      w_data,
    output logic                       w_valid,
    input  logic                       w_ready,
    output logic                       w_last
`ifdef WEIGHT_STREAMER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0]      checksum
`endif
);

    localparam int AW = BRAM_ADDR_WIDTH;
    localparam logic [AW:0]   DEPTH_N   = (AW+1)'(MEM_DEPTH);
    localparam logic [AW:0]   ONE_N     = (AW+1)'(1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t                r_state, w_state_nxt;
    logic [AW-1:0]         r_issue_addr;
    logic [AW:0]           r_issue_left;
    logic [AW:0]           r_out_left;
    logic                  r_rd_vld_p1;
    logic [DATA_WIDTH-1:0] r_fifo_mem [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;

    logic [AW:0]           w_num_clamped;
    logic                  w_accept;
    logic                  w_rd_en;
    logic [AW-1:0]         w_rd_addr;
    logic                  w_fifo_vld;
    logic                  w_pop;
    logic                  w_room;
    logic [DATA_WIDTH-1:0] w_head;

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + AW'(1);
    endfunction

    function automatic logic [AW:0] clamp_words(input logic [AW:0] n);
        return (n > DEPTH_N) ? DEPTH_N : n;
    endfunction

    assign w_num_clamped = clamp_words(num_words);
    assign w_fifo_vld    = (r_count != 2'd0);
    assign w_head        = r_fifo_mem[r_rd_ptr];
    assign w_pop         = w_fifo_vld && w_ready;
    // Room is judged after this cycle's pop so a full-rate stream keeps one read in flight.
    assign w_room = ({1'b0, r_count} + {2'b00, r_rd_vld_p1}) < (3'd2 + {2'b00, w_pop});

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_rd_en     = 1'b0;
        w_rd_addr   = r_issue_addr;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    if (w_num_clamped == '0) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = RUN;
                        w_rd_en     = 1'b1;
                        w_rd_addr   = base_addr;
                    end
                end
            end
            RUN: begin
                w_rd_en = (r_issue_left != '0) && w_room;
                if (w_pop && (r_out_left == ONE_N)) w_state_nxt = DONE;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // p1: read data returns one cycle after bram_en and is pushed on that edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_vld_p1  <= 1'b0;
            r_issue_addr <= '0;
            r_issue_left <= '0;
            r_out_left   <= '0;
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_count      <= 2'd0;
        end else begin
            r_rd_vld_p1 <= w_rd_en;
            if (w_accept) begin
                r_issue_addr <= next_addr(base_addr);
                r_issue_left <= (w_num_clamped == '0) ? '0 : w_num_clamped - ONE_N;
                r_out_left   <= w_num_clamped;
            end else begin
                if (w_rd_en) begin
                    r_issue_addr <= next_addr(r_issue_addr);
                    r_issue_left <= r_issue_left - ONE_N;
                end
                if (w_pop) r_out_left <= r_out_left - ONE_N;
            end
            if (r_rd_vld_p1) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)       r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, r_rd_vld_p1} - {1'b0, w_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (r_rd_vld_p1) r_fifo_mem[r_wr_ptr] <= bram_dout;
    end

    assign busy      = !rst && (r_state != IDLE);
    assign done      = !rst && (r_state == DONE);
    assign bram_en   = !rst && w_rd_en;
    assign bram_addr = bram_en ? w_rd_addr : '0;
    assign w_valid   = !rst && w_fifo_vld;
    assign w_data    = w_valid ? w_head : '0;
    assign w_last    = w_valid && (r_out_left == ONE_N);

`ifdef WEIGHT_STREAMER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_checksum;

    always_ff @(posedge clk) begin
        if (rst)           r_checksum <= '0;
        else if (w_accept) r_checksum <= '0;
        else if (w_pop)    r_checksum <= r_checksum + w_head;
    end

    assign checksum = rst ? '0 : r_checksum;
`endif

endmodule

// File: tb/tb_weight_streamer.sv
// Scoreboard bench for weight_streamer: expected words/addresses are queued at start,
// a negedge monitor pops and compares every BRAM read and every stream handshake.
module tb_weight_streamer;

    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   num_words;
    logic          busy, done;
    logic [AW-1:0] bram_addr;
    logic          bram_en;
    logic [DW-1:0] bram_dout;
    logic [DW-1:0] w_data;
    logic          w_valid, w_ready, w_last;
`ifdef WEIGHT_STREAMER_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    weight_streamer #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .BRAM_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
        .busy(busy), .done(done), .bram_addr(bram_addr), .bram_en(bram_en),
        .bram_dout(bram_dout), .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
        .w_last(w_last)
`ifdef WEIGHT_STREAMER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM with one-cycle read latency
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) if (bram_en) bram_dout <= mem[bram_addr];

    int n_chk = 0;
    int n_fail = 0;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    logic [DW:0]   exp_data_q [$];
    logic [AW-1:0] exp_addr_q [$];
    int hs_cnt, en_cnt, vld_cnt, issued;
    int first_vld_cyc, first_hs_cyc, last_hs_cyc;
    int ready_mode = 0;
    int ph = 0;
    bit prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic [DW:0]   e;

    task automatic reset_mon();
        hs_cnt = 0; en_cnt = 0; vld_cnt = 0; issued = 0;
        first_vld_cyc = -1; first_hs_cyc = -1; last_hs_cyc = -1; ph = 0;
    endtask

    task automatic flush();
        exp_data_q.delete();
        exp_addr_q.delete();
    endtask

    initial begin
        w_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       w_ready = 1'b1;
                1:       begin w_ready = ((ph % 4) == 0) || ((ph % 4) == 3); ph++; end
                default: w_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) check_eq("stall_hold", {w_valid, w_data}, {1'b1, prev_data});
            check_eq("buffered_le2", ((issued - hs_cnt) <= 2), 1);
            if (!w_valid) check_eq("last_without_valid", w_last, 0);
            if (w_valid) begin
                vld_cnt++;
                if (first_vld_cyc < 0) first_vld_cyc = cyc;
            end
            if (w_valid && w_ready) begin
                check_eq("word_expected", (exp_data_q.size() != 0), 1);
                if (exp_data_q.size() != 0) begin
                    e = exp_data_q.pop_front();
                    check_eq("w_data", w_data, e[DW-1:0]);
                    check_eq("w_last", w_last, e[DW]);
                end
                hs_cnt++;
                if (first_hs_cyc < 0) first_hs_cyc = cyc;
                last_hs_cyc = cyc;
            end
            if (bram_en) begin
                check_eq("read_expected", (exp_addr_q.size() != 0), 1);
                if (exp_addr_q.size() != 0) check_eq("bram_addr", bram_addr, exp_addr_q.pop_front());
                en_cnt++;
                issued++;
            end
        end
        prev_stall = !rst && w_valid && !w_ready;
        prev_data  = w_data;
    end

    task automatic do_reset();
        @(posedge clk); #1; rst = 1'b1; start = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        flush();
        reset_mon();
    endtask

    task automatic run_pass(input int base, input int n, input int rmode, input bit restart);
        int nc, st, lim, a;
        bit seen;
        logic [DW-1:0] sum;
        nc  = (n > DEPTH) ? DEPTH : n;
        sum = '0;
        @(posedge clk); #1;
        reset_mon();
        ready_mode = rmode;
        for (int k = 0; k < nc; k++) begin
            a = (base + k) % DEPTH;
            exp_addr_q.push_back(AW'(a));
            exp_data_q.push_back({(k == nc - 1), mem[a]});
            sum = sum + mem[a];
        end
        start = 1'b1; base_addr = AW'(base); num_words = (AW+1)'(n); st = cyc;
        @(posedge clk); #1;
        start = 1'b0; base_addr = AW'($urandom); num_words = (AW+1)'($urandom);
        lim  = 16 * nc + 50;
        seen = 1'b0;
        for (int i = 0; i < lim && !seen; i++) begin
            @(negedge clk);
            if (i == 0) check_eq("busy_after_start", busy, 1);
            if (done) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                start = restart && (i == 2);
            end
        end
        start = 1'b0;
        if (!seen) begin
            n_chk++; n_fail++;
            $display("FAIL done_timeout: no done after %0d cycles, required done for %0d words", lim, nc);
            do_reset();
            return;
        end
        check_eq("words_left", exp_data_q.size(), 0);
        check_eq("reads_left", exp_addr_q.size(), 0);
        check_eq("word_count", hs_cnt, nc);
        if (nc == 0) begin
            check_eq("zero_done_latency", cyc - st, 1);
            check_eq("zero_no_reads", en_cnt, 0);
            check_eq("zero_no_valid", vld_cnt, 0);
        end else begin
            check_eq("first_valid_latency", first_vld_cyc - st, 2);
            check_eq("done_after_last", cyc - last_hs_cyc, 1);
            if (rmode == 0) check_eq("back_to_back", last_hs_cyc - first_hs_cyc, nc - 1);
        end
`ifdef WEIGHT_STREAMER_CHECKSUM_EN
        check_eq("checksum", checksum, sum);
`endif
        @(negedge clk);
        check_eq("done_one_cycle", {done, busy}, 2'b00);
    endtask

    task automatic reset_mid_pass();
        int a;
        @(posedge clk); #1;
        reset_mon();
        ready_mode = 0;
        for (int k = 0; k < 10; k++) begin
            a = 100 + k;
            exp_addr_q.push_back(AW'(a));
            exp_data_q.push_back({(k == 9), mem[a]});
        end
        start = 1'b1; base_addr = AW'(100); num_words = (AW+1)'(10);
        @(posedge clk); #1; start = 1'b0;
        for (int i = 0; i < 100 && hs_cnt < 3; i++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check_eq("rst_ctrl_outputs", {busy, done, bram_en, w_valid, w_last}, 5'b0);
        check_eq("rst_w_data", w_data, 0);
        check_eq("rst_bram_addr", bram_addr, 0);
        check_eq("rst_words_before", hs_cnt, 3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("rst_no_done", {done, w_valid, bram_en}, 3'b0);
        end
        flush();
        run_pass(100, 10, 0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
        reset_mon();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_ctrl", {busy, done, bram_en, w_valid, w_last}, 5'b0);
        check_eq("reset_data", w_data, 0);
        check_eq("reset_addr", bram_addr, 0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check_eq("idle_ctrl", {busy, done, bram_en, w_valid}, 4'b0);

        run_pass(0, 8, 0, 1'b0);
        run_pass(1020, 6, 0, 1'b0);
        run_pass(5, 16, 1, 1'b0);
        run_pass(0, 0, 0, 1'b0);
        reset_mid_pass();
        run_pass(3, 2047, 0, 1'b0);
        run_pass(900, 20, 0, 1'b1);

        mem[0] = 32'hFFFF_FFFF;
        mem[1] = 32'h0000_0002;
        run_pass(0, 2, 0, 1'b0);

        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        for (int t = 0; t < 12; t++) begin
            int n;
            n = $urandom_range(1, 40);
            run_pass($urandom_range(0, DEPTH - 1), n, $urandom_range(0, 2),
                     (n >= 8) && ($urandom_range(0, 1) == 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/weight_streamer.md
WEIGHT_STREAMER -- requirements
Module: weight_streamer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the weight word width.
REQ-002 SHALL have parameter MEM_DEPTH, default 1024, meaning the BRAM depth in words.
REQ-003 SHALL have parameter BRAM_ADDR_WIDTH, default $clog2(MEM_DEPTH), meaning the BRAM address bits.
REQ-004 SHALL have port clk, input, 1 bit, meaning the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, meaning a synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit, a pulse that begins one streaming pass.
REQ-007 SHALL have port base_addr, input, BRAM_ADDR_WIDTH bits, meaning the first BRAM word to stream; sampled on accepted start.
REQ-008 SHALL have port num_words, input, BRAM_ADDR_WIDTH+1 bits, meaning the word count; sampled on accepted start.
REQ-009 SHALL have port busy, output, 1 bit, high from the accepted start until done.
REQ-010 SHALL have port done, output, 1 bit, a one-cycle pulse at the end of the pass.
REQ-011 SHALL have ports bram_addr (output, BRAM_ADDR_WIDTH), bram_en (output, 1) and bram_dout (input, DATA_WIDTH): a BRAM read port with 1-cycle read latency.
REQ-012 SHALL have ports w_data (output, DATA_WIDTH), w_valid (output, 1), w_ready (input, 1) and w_last (output, 1): the weight stream to the compute array.

Function
REQ-013 SHALL use FSM states IDLE, RUN and DONE.
REQ-014 SHALL transition IDLE->RUN on start.
REQ-015 SHALL transition RUN->DONE on the cycle the final word handshakes (w_valid && w_ready).
REQ-016 SHALL transition DONE->IDLE unconditionally, with done=1 for that single cycle.
REQ-017 SHALL ignore start while busy=1.
REQ-018 SHALL clamp num_words greater than MEM_DEPTH to MEM_DEPTH.
REQ-019 SHALL, when num_words==0, go IDLE->DONE directly, pulse done the cycle after start, and emit no words and no BRAM reads.
REQ-020 SHALL read word k at bram_addr = (base_addr + k) mod MEM_DEPTH, wrapping past MEM_DEPTH-1 to 0.
REQ-021 SHALL contain a 2-entry output FIFO; it SHALL assert bram_en only when (FIFO occupancy + reads in flight) < 2 and words remain to be issued.
REQ-022 SHALL capture bram_dout into the FIFO exactly one cycle after each bram_en.
REQ-023 SHALL present words in address order on w_data with w_valid=1 whenever the FIFO is non-empty; it SHALL never drop or duplicate a word.
REQ-024 SHALL hold w_data and w_valid stable while w_valid && !w_ready.
REQ-025 SHALL, with w_ready held high, achieve a sustained throughput of one word per cycle; the first w_valid SHALL appear 2 cycles after the start cycle.
REQ-026 SHALL assert w_last together with w_valid on the final word only.
REQ-027 SHALL handle a simultaneous FIFO push and pop in the same cycle with no change in occupancy.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, force state IDLE, empty the FIFO and clear all counters, regardless of state.
REQ-029 SHALL drive every output to 0 while in reset: busy, done, bram_en, bram_addr, w_valid, w_data, w_last and checksum.
REQ-030 SHALL, on reset mid-pass, abandon the pass with no done pulse, and discard any read data returning after reset.

Configuration
REQ-031 SHALL, with the macro WEIGHT_STREAMER_CHECKSUM_EN defined, add output checksum (DATA_WIDTH bits).
REQ-032 SHALL, with WEIGHT_STREAMER_CHECKSUM_EN defined, clear checksum to 0 on accepted start and add each handshaken w_data to it modulo 2^DATA_WIDTH; checksum SHALL be valid and stable while done=1 and hold until the next accepted start.
REQ-033 SHALL, without WEIGHT_STREAMER_CHECKSUM_EN, have no checksum port and no accumulator logic.

Verification
REQ-034 SHALL cover: BRAM[i]=i, base_addr=0, num_words=8, w_ready=1 -> w_data 0..7 on 8 consecutive cycles, w_last with 7, done one cycle after the last handshake.
REQ-035 SHALL cover: base_addr=1020, num_words=6, MEM_DEPTH=1024 -> read addresses 1020,1021,1022,1023,0,1 in order.
REQ-036 SHALL cover: w_ready toggling 1,0,0,1 repeating over num_words=16 -> all 16 words delivered once and in order, w_data stable during stalls, never more than 2 words buffered.
REQ-037 SHALL cover: num_words=0 -> done pulses 1 cycle after start, w_valid and bram_en never asserted.
REQ-038 SHALL cover: rst asserted after 3 of 10 words -> all outputs 0 the next cycle, no done; a new start then streams correctly from word 0.
REQ-039 SHALL cover, with WEIGHT_STREAMER_CHECKSUM_EN: BRAM words 0xFFFFFFFF,0x00000002 -> checksum 0x00000001 at done.
